wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_W, 32, beat data width; matches the 32-bit 2:1 datapath mux.
  ADDR_W, 5, beat destination address width.
  MAX_BEATS, 8, maximum beats per grant before forced release; legal range 1..255.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. There is one clock; reset is asynchronous and active-low.
  clk  in  1  clock; all state changes on rising edge.
  reset_n  in  1  asynchronous active-low reset.
  stall_i  in  1  downstream busy; blocks acceptance of beats.
  req0_valid  in  1  requester 0 beat valid.
  req0_last  in  1  requester 0 final beat of burst.
  req0_addr  in  ADDR_W  requester 0 destination address.
  req0_data  in  DATA_W  requester 0 data.
  req0_ready  out  1  requester 0 beat accepted this cycle.
  req1_valid, req1_last, req1_addr, req1_data, req1_ready: same as the req0 signals, for requester 1.
  mux_sel  out  1  select for the 2:1 datapath mux; 0 selects requester 0, 1 selects requester 1.
  out_valid  out  1  registered beat valid.
  out_addr  out  ADDR_W  registered beat address.
  out_data  out  DATA_W  registered beat data.
  overrun  out  1  one-cycle pulse when a grant is force-released at MAX_BEATS.

Function
REQ-003 FSM states SHALL be IDLE, OWN0 and OWN1; mux_sel SHALL be 1 in OWN1 and 0 otherwise.
REQ-004 Beat transfer on requester i SHALL occur when state is OWNi, reqi_valid is 1 and stall_i is 0; reqi_ready SHALL equal exactly this condition, combinationally.
REQ-005 In IDLE, both ready outputs SHALL be 0 (one-cycle arbitration bubble).
REQ-006 In IDLE, with only reqi_valid high, the next state SHALL be OWNi.
REQ-007 In IDLE, with both valid, the next state SHALL be OWNx, where x is the requester not recorded in last_grant.
REQ-008 In IDLE, with neither valid, the FSM SHALL stay in IDLE.
REQ-009 last_grant SHALL update to i on every entry into OWNi.
REQ-010 A beat counter SHALL clear on grant entry and increment per transferred beat; its width SHALL be 8 bits.
REQ-011 A grant SHALL end on the cycle a beat transfers with reqi_last=1, or with the beat count reaching MAX_BEATS.
REQ-012 At grant end, the next state SHALL be OWN of the other requester if its valid is high that cycle; otherwise it SHALL be IDLE.
REQ-013 A grant ended by count without last SHALL pulse overrun for exactly one cycle, one cycle after that beat.
REQ-014 A last beat that coincides with the count reaching MAX_BEATS SHALL NOT pulse overrun.
REQ-015 In OWNi with reqi_valid low and no stall, the FSM SHALL hold OWNi; there is no timeout.
REQ-016 Output latency SHALL be one cycle: out_valid/out_addr/out_data SHALL register the transferred beat; out_valid SHALL be 0 on cycles after no transfer.
REQ-017 out_addr/out_data SHALL hold their last values while out_valid is 0.
REQ-018 stall_i SHALL freeze the FSM and the counter, and SHALL NOT affect a beat already registered.

Reset
REQ-019 While reset_n is 0, asynchronously: state IDLE, last_grant 1 (requester 0 wins the first tie), counter 0, mux_sel 0, out_valid 0, out_addr 0, out_data 0, overrun 0, both ready 0.
REQ-020 Reset asserted mid-burst SHALL abandon the burst; after release, arbitration SHALL restart from IDLE with no beat replayed.

Verification
REQ-021 Both requesters valid from reset, 2-beat bursts each -> grant order 0,1,0,1; mux_sel 0,0,1,1; no IDLE bubble between bursts.
REQ-022 req0 single beat addr=3 data=0xDEADBEEF -> cycle 1 IDLE, cycle 2 req0_ready=1, cycle 3 out_valid=1, out_addr=3, out_data=0xDEADBEEF.
REQ-023 MAX_BEATS=8, req1 streams 10 beats with no last -> 8 accepted, overrun pulses once, then re-arbitration to IDLE/OWN.
REQ-024 stall_i high for 3 cycles mid-burst -> ready 0, out_valid 0 after the in-flight beat, counter frozen, burst resumes intact.
REQ-025 reset_n low during beat 2 of a 4-beat burst -> all outputs 0 immediately; after release the first tie is granted to requester 0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Two-requester beat arbiter: round-robin on ties, per-grant beat cap with
// forced release, and a registered output stage behind the 2:1 data mux.
module wb_port_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int MAX_BEATS = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall_i,
  input  logic              req0_valid,
  input  logic              req0_last,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_last,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              mux_sel,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              overrun
);

  // state | meaning
  // IDLE  | no owner; one-cycle arbitration bubble, both ready low
  // OWN0  | requester 0 holds the datapath
  // OWN1  | requester 1 holds the datapath
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [8:0] MAX_CNT = 9'(MAX_BEATS);

  state_t     state;
  state_t     state_nxt;
  logic       last_grant;
  logic [7:0] beat_cnt;

  logic own0;
  logic own1;
  logic xfer0;
  logic xfer1;
  logic xfer;
  logic cur_last;
  logic count_hit;
  logic grant_end;
  logic grant_entry;

  assign own0      = (state == OWN0);
  assign own1      = (state == OWN1);
  assign xfer0     = own0 & req0_valid & ~stall_i;
  assign xfer1     = own1 & req1_valid & ~stall_i;
  assign xfer      = xfer0 | xfer1;
  assign cur_last  = own1 ? req1_last : req0_last;
  // compare the post-increment count so the capping beat itself ends the grant
  assign count_hit = (({1'b0, beat_cnt} + 9'd1) == MAX_CNT);
  assign grant_end = xfer & (cur_last | count_hit);
  assign grant_entry = (state_nxt != state) && (state_nxt != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // stall freezes arbitration as well as an active grant
  always_comb begin
    state_nxt = state;
    if (!stall_i) begin
      case (state)
        IDLE: begin
          if (req0_valid && req1_valid) begin
            state_nxt = last_grant ? OWN0 : OWN1;
          end else if (req0_valid) begin
            state_nxt = OWN0;
          end else if (req1_valid) begin
            state_nxt = OWN1;
          end
        end
        OWN0: begin
          if (grant_end) begin
            state_nxt = req1_valid ? OWN1 : IDLE;
          end
        end
        OWN1: begin
          if (grant_end) begin
            state_nxt = req0_valid ? OWN0 : IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    req0_ready = xfer0;
    req1_ready = xfer1;
    mux_sel    = own1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      beat_cnt   <= 8'd0;
    end else if (grant_entry) begin
      last_grant <= (state_nxt == OWN1);
      beat_cnt   <= 8'd0;
    end else if (grant_end) begin
      beat_cnt   <= 8'd0;
    end else if (xfer) begin
      beat_cnt   <= beat_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= xfer;
      overrun   <= grant_end & count_hit & ~cur_last;
      if (xfer) begin
        out_addr <= own1 ? req1_addr : req0_addr;
        out_data <= own1 ? req1_data : req0_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: an owner/count reference model predicts
// ready and grant hand-off; a monitor checks the registered beat stream.
module tb_wb_port_arbiter;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int MAXB = 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          stall_i;
  logic          req0_valid, req0_last, req0_ready;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req1_valid, req1_last, req1_ready;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          mux_sel, out_valid, overrun;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;

  wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .reset_n(reset_n), .stall_i(stall_i),
    .req0_valid(req0_valid), .req0_last(req0_last), .req0_addr(req0_addr),
    .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_last(req1_last), .req1_addr(req1_addr),
    .req1_data(req1_data), .req1_ready(req1_ready),
    .mux_sel(mux_sel), .out_valid(out_valid), .out_addr(out_addr),
    .out_data(out_data), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  beat_t bq0[$];
  beat_t bq1[$];
  beat_t sb[$];
  int    acc_src[$];

  int            owner = -1;
  int            mlast = 1;
  int            mcnt = 0;
  bit            exp_ov = 1'b0;
  bit            exp_ovr = 1'b0;
  logic [AW-1:0] hold_addr = '0;
  logic [DW-1:0] hold_data = '0;
  int            acc_total = 0;
  int            ovr_cnt = 0;
  int            acc_at_ovr = -1;
  bit            gate_rand = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_burst(input int who, input int len, input bit with_last);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.addr = AW'($urandom);
      b.data = $urandom;
      b.last = with_last && (k == len - 1);
      if (who == 0) bq0.push_back(b);
      else bq1.push_back(b);
    end
  endtask

  // Reference: one owner at a time, tie goes to whoever did not own last,
  // grant ends on last or on the MAXB-th beat, stall freezes everything.
  task automatic model_cycle(input bit v0, input bit v1, input bit st);
    beat_t b;
    int    oth;
    chk("ready0", 64'(req0_ready), 64'(owner == 0 && v0 && !st));
    chk("ready1", 64'(req1_ready), 64'(owner == 1 && v1 && !st));
    chk("mux_sel", 64'(mux_sel), 64'(owner == 1));
    exp_ov  = 1'b0;
    exp_ovr = 1'b0;
    if (st) return;
    if (owner < 0) begin
      if (v0 && v1) owner = (mlast == 1) ? 0 : 1;
      else if (v0) owner = 0;
      else if (v1) owner = 1;
      if (owner >= 0) begin
        mlast = owner;
        mcnt  = 0;
      end
    end else if ((owner == 0 && v0) || (owner == 1 && v1)) begin
      if (owner == 0) b = bq0.pop_front();
      else b = bq1.pop_front();
      sb.push_back(b);
      exp_ov = 1'b1;
      mcnt++;
      if (b.last || mcnt == MAXB) begin
        exp_ovr = !b.last;
        oth = 1 - owner;
        owner = ((oth == 0) ? v0 : v1) ? oth : -1;
        if (owner >= 0) begin
          mlast = owner;
          mcnt  = 0;
        end
      end
    end
  endtask

  task automatic step(input bit st);
    bit v0, v1;
    @(negedge clk);
    v0 = (bq0.size() > 0) && (!gate_rand || $urandom_range(0, 99) < 85);
    v1 = (bq1.size() > 0) && (!gate_rand || $urandom_range(0, 99) < 85);
    stall_i    = st;
    req0_valid = v0;
    req1_valid = v1;
    if (bq0.size() > 0) begin
      req0_addr = bq0[0].addr; req0_data = bq0[0].data; req0_last = bq0[0].last;
    end else begin
      req0_addr = AW'($urandom); req0_data = $urandom; req0_last = 1'($urandom);
    end
    if (bq1.size() > 0) begin
      req1_addr = bq1[0].addr; req1_data = bq1[0].data; req1_last = bq1[0].last;
    end else begin
      req1_addr = AW'($urandom); req1_data = $urandom; req1_last = 1'($urandom);
    end
    #1;
    if (req0_ready) begin acc_src.push_back(0); acc_total++; end
    if (req1_ready) begin acc_src.push_back(1); acc_total++; end
    model_cycle(v0, v1, st);
  endtask

  task automatic do_reset(input int cyc);
    reset_n    = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    stall_i    = 1'b0;
    #1;
    chk("rst_ready0", 64'(req0_ready), 64'd0);
    chk("rst_ready1", 64'(req1_ready), 64'd0);
    chk("rst_mux_sel", 64'(mux_sel), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_addr", 64'(out_addr), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    owner = -1; mlast = 1; mcnt = 0;
    exp_ov = 1'b0; exp_ovr = 1'b0;
    hold_addr = '0; hold_data = '0;
    sb.delete(); bq0.delete(); bq1.delete();
    repeat (cyc) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin : monitor
    beat_t mb;
    forever begin
      @(posedge clk);
      #1;
      chk("out_valid", 64'(out_valid), 64'(exp_ov));
      chk("overrun", 64'(overrun), 64'(exp_ovr));
      if (overrun) begin
        ovr_cnt++;
        acc_at_ovr = acc_total;
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_beat: got unexpected beat addr=%0h data=%0h", out_addr, out_data);
        end else begin
          mb = sb.pop_front();
          chk("out_addr", 64'(out_addr), 64'(mb.addr));
          chk("out_data", 64'(out_data), 64'(mb.data));
          hold_addr = mb.addr;
          hold_data = mb.data;
        end
      end else begin
        chk("hold_addr", 64'(out_addr), 64'(hold_addr));
        chk("hold_data", 64'(out_data), 64'(hold_data));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int    n;
    beat_t b;
    req0_addr = '0; req0_data = '0; req0_last = 1'b0;
    req1_addr = '0; req1_data = '0; req1_last = 1'b0;
    do_reset(2);

    // single beat: bubble, accept, registered one cycle later
    b.addr = 5'd3; b.data = 32'hDEADBEEF; b.last = 1'b1;
    bq0.push_back(b);
    step(1'b0);
    chk("t022_c1_ready0", 64'(req0_ready), 64'd0);
    step(1'b0);
    chk("t022_c2_ready0", 64'(req0_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("t022_c3_valid", 64'(out_valid), 64'd1);
    chk("t022_c3_addr", 64'(out_addr), 64'd3);
    chk("t022_c3_data", 64'(out_data), 64'hDEADBEEF);

    // alternating 2-beat bursts from reset, no bubble on hand-off
    do_reset(2);
    repeat (2) begin
      push_burst(0, 2, 1'b1);
      push_burst(1, 2, 1'b1);
    end
    acc_src.delete();
    n = 0;
    while ((bq0.size() > 0 || bq1.size() > 0) && n < 40) begin
      step(1'b0);
      n++;
    end
    chk("t021_cycles", 64'(n), 64'd9);
    chk("t021_beats", 64'(acc_src.size()), 64'd8);
    for (int k = 0; k < acc_src.size() && k < 8; k++) begin
      chk("t021_src", 64'(acc_src[k]), 64'((k / 2) % 2));
    end

    // 10 beats without last: forced release after MAXB
    acc_total = 0; ovr_cnt = 0; acc_at_ovr = -1;
    push_burst(1, 10, 1'b0);
    repeat (14) step(1'b0);
    chk("t023_ovr_cnt", 64'(ovr_cnt), 64'd1);
    chk("t023_beats_at_ovr", 64'(acc_at_ovr), 64'(MAXB));
    chk("t023_beats_total", 64'(acc_total), 64'd10);

    // stall for 3 cycles mid-burst, burst then completes intact
    acc_total = 0; ovr_cnt = 0;
    push_burst(1, 4, 1'b1);
    step(1'b0); step(1'b0);
    step(1'b1); step(1'b1); step(1'b1);
    chk("t024_beats_before_resume", 64'(acc_total), 64'd2);
    n = 0;
    while (bq1.size() > 0 && n < 10) begin
      step(1'b0);
      n++;
    end
    chk("t024_beats", 64'(acc_total), 64'd4);
    chk("t024_ovr", 64'(ovr_cnt), 64'd0);

    // randomized traffic with stalls and withdrawn valids
    gate_rand = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (bq0.size() == 0 && $urandom_range(0, 3) == 0)
        push_burst(0, $urandom_range(1, 11), $urandom_range(0, 99) < 85);
      if (bq1.size() == 0 && $urandom_range(0, 3) == 0)
        push_burst(1, $urandom_range(1, 11), $urandom_range(0, 99) < 85);
      step($urandom_range(0, 99) < 20);
    end
    gate_rand = 1'b0;

    // reset during beat 2 of a 4-beat burst
    do_reset(1);
    push_burst(1, 4, 1'b1);
    step(1'b0); step(1'b0); step(1'b0);
    chk("t025_beat2_live", 64'(req1_ready), 64'd1);
    do_reset(2);
    push_burst(0, 1, 1'b1);
    push_burst(1, 1, 1'b1);
    acc_src.delete();
    repeat (3) step(1'b0);
    chk("t025_beats", 64'(acc_src.size()), 64'd2);
    if (acc_src.size() > 0) chk("t025_first_grant", 64'(acc_src[0]), 64'd0);
    repeat (3) step(1'b0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
